// File: rtl/fifo_apb_port.sv
// fifo_apb_port: APB slave driving a single-write/single-read FIFO macro.
// Owns pointers, occupancy, threshold/error flags and the threshold interrupt.
module fifo_apb_port #(
    parameter int DEPTH = 256,
    parameter int AW = 8,
    parameter int DW = 9
) (
    input  logic          PCLK,
    input  logic          PRESET,
    input  logic          PSEL,
    input  logic          PENABLE,
    input  logic          PWRITE,
    input  logic [3:0]    PADDR,
    input  logic [31:0]   PWDATA,
    output logic [31:0]   PRDATA,
    output logic          PREADY,
    output logic          PSLVERR,
    output logic [AW-1:0] WADDR,
    output logic [AW-1:0] RADDR,
    output logic [DW-1:0] FIFO_DIN,
    output logic          WRB,
    output logic          RDB,
    input  logic [DW-1:0] FIFO_DO,
    output logic [2:0]    DC_OUT,
    output logic          IRQ
);
    localparam logic [0:0] IDLE = 1'b0, RD_WAIT = 1'b1;
    logic [0:0] state;
    logic [AW-1:0] wptr, rptr;
    logic [AW:0] count, thr;
    logic ovf, udf;
    logic [3:0] ctrl;
    logic acc, wr, rd, empty, full, eqth, geqth;
    logic sel_data, sel_stat, sel_thr, sel_ctrl;
    logic push, pop_req, pop_done, ovf_hit, udf_hit;
    logic [8:0] tw;
    logic [31:0] status;
    logic unused_wdata;
    assign unused_wdata = ^PWDATA[31:9];
    assign acc = PSEL & PENABLE;
    assign wr = acc & PWRITE;
    assign rd = acc & ~PWRITE;
    assign sel_data = PADDR == 4'h0;
    assign sel_stat = PADDR == 4'h4;
    assign sel_thr = PADDR == 4'h8;
    assign sel_ctrl = PADDR == 4'hC;
    assign empty = count == '0;
    assign full = count == (AW+1)'(DEPTH);
    assign eqth = count == thr;
    assign geqth = count >= thr;
    assign push = wr & sel_data & ~full;
    assign ovf_hit = wr & sel_data & full;
    // The pop is split: strobe in IDLE, data returns from the macro in RD_WAIT.
    assign pop_req = rd & sel_data & ~empty & (state == IDLE);
    assign udf_hit = rd & sel_data & empty & (state == IDLE);
    assign pop_done = state == RD_WAIT;
    assign tw = PWDATA[8:0];
    assign status = 32'({count, 2'b0, udf, ovf, geqth, eqth, full, empty});
    assign WRB = ~push;
    assign RDB = ~pop_req;
    assign WADDR = wptr;
    assign RADDR = rptr;
    assign FIFO_DIN = push ? PWDATA[DW-1:0] : '0;
    assign DC_OUT = ctrl[2:0];
    assign PREADY = ~pop_req;
    assign PSLVERR = ovf_hit | udf_hit;
    assign PRDATA = pop_done ? 32'(FIFO_DO) : ~rd ? '0 : sel_stat ? status :
                    sel_thr ? 32'(thr) : sel_ctrl ? {28'b0, ctrl} : '0;
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state <= IDLE;
            wptr <= '0;
            rptr <= '0;
            count <= '0;
            thr <= (AW+1)'(DEPTH / 2);
            ovf <= 1'b0;
            udf <= 1'b0;
            ctrl <= '0;
            IRQ <= 1'b0;
        end else begin
            state <= pop_req ? RD_WAIT : IDLE;
            IRQ <= ctrl[3] & geqth;
            if (push) begin
                wptr <= wptr + 1'b1;
                count <= count + 1'b1;
            end
            if (pop_done) begin
                rptr <= rptr + 1'b1;
                count <= count - 1'b1;
            end
            if (ovf_hit) ovf <= 1'b1;
            if (udf_hit) udf <= 1'b1;
            if (wr & sel_stat) begin
                if (PWDATA[4]) ovf <= 1'b0;
                if (PWDATA[5]) udf <= 1'b0;
            end
            if (wr & sel_thr) thr <= (tw > 9'(DEPTH)) ? (AW+1)'(DEPTH) : (AW+1)'(tw);
            if (wr & sel_ctrl) begin
                ctrl <= PWDATA[3:0];
                if (PWDATA[4]) begin
                    wptr <= '0;
                    rptr <= '0;
                    count <= '0;
                end
            end
        end
    end
endmodule

// File: tb/tb_fifo_apb_port.sv
// tb_fifo_apb_port: directed/randomized APB sequence checked against a queue model.
module tb_fifo_apb_port;
    localparam int DEPTH = 256;
    logic PCLK, PRESET, PSEL, PENABLE, PWRITE;
    logic [3:0] PADDR;
    logic [31:0] PWDATA, PRDATA;
    logic PREADY, PSLVERR, WRB, RDB, IRQ;
    logic [7:0] WADDR, RADDR;
    logic [8:0] FIFO_DIN, FIFO_DO;
    logic [2:0] DC_OUT;
    logic [8:0] mem [256];

    fifo_apb_port #(.DEPTH(DEPTH), .AW(8), .DW(9)) dut (
        .PCLK(PCLK), .PRESET(PRESET), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
        .WADDR(WADDR), .RADDR(RADDR), .FIFO_DIN(FIFO_DIN), .WRB(WRB), .RDB(RDB),
        .FIFO_DO(FIFO_DO), .DC_OUT(DC_OUT), .IRQ(IRQ)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    // Behavioural model of the FIFO macro: registered read, valid the cycle after RDB low.
    always @(posedge PCLK) begin
        if (!WRB) mem[WADDR] <= FIFO_DIN;
        if (!RDB) FIFO_DO <= mem[RADDR];
    end

    int tests = 0, fails = 0;
    logic [8:0] q[$];
    int wp = 0, rp = 0, thr_m = DEPTH / 2;
    logic ovf_m = 0, udf_m = 0;
    logic [3:0] ctrl_m = 0;
    logic s_wrb, s_rdb, s_ready, c_rdb, err;
    logic [7:0] s_waddr, s_raddr;
    logic [8:0] s_din;
    logic [31:0] rdata;
    int waits;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_status();
        int c = q.size();
        return {15'b0, 9'(c), 2'b0, udf_m, ovf_m, c >= thr_m, c == thr_m, c == DEPTH, c == 0};
    endfunction

    task automatic apb(input logic w, input logic [3:0] a, input logic [31:0] d);
        @(negedge PCLK);
        PSEL = 1; PENABLE = 0; PWRITE = w; PADDR = a; PWDATA = d;
        @(negedge PCLK);
        PENABLE = 1;
        #1;
        s_wrb = WRB; s_waddr = WADDR; s_din = FIFO_DIN;
        s_rdb = RDB; s_raddr = RADDR; s_ready = PREADY;
        waits = 0;
        while (!PREADY && waits < 8) begin
            @(negedge PCLK);
            #1;
            waits++;
        end
        rdata = PRDATA; err = PSLVERR; c_rdb = RDB;
        @(negedge PCLK);
        PSEL = 0; PENABLE = 0;
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        apb(1, a, d);
        chk("wr_err", 32'(err), 0);
        chk("wr_waits", 32'(waits), 0);
    endtask

    task automatic rd(input logic [3:0] a, input logic [31:0] exp, input string tag);
        apb(0, a, 0);
        chk(tag, rdata, exp);
        chk("rd_err", 32'(err), 0);
    endtask

    task automatic push(input logic [8:0] d);
        apb(1, 4'h0, {$urandom_range(0, 8388607), d});
        if (q.size() == DEPTH) begin
            chk("push_full_err", 32'(err), 1);
            chk("push_full_wrb", 32'(s_wrb), 1);
            ovf_m = 1;
        end else begin
            chk("push_wrb", 32'(s_wrb), 0);
            chk("push_rdb", 32'(s_rdb), 1);
            chk("push_waddr", 32'(s_waddr), 32'(wp));
            chk("push_din", 32'(s_din), 32'(d));
            chk("push_err", 32'(err), 0);
            chk("push_waits", 32'(waits), 0);
            q.push_back(d);
            wp = (wp + 1) % DEPTH;
        end
    endtask

    task automatic pop();
        apb(0, 4'h0, 0);
        if (q.size() == 0) begin
            chk("pop_empty_data", rdata, 0);
            chk("pop_empty_err", 32'(err), 1);
            chk("pop_empty_rdb", 32'(s_rdb), 1);
            chk("pop_empty_waits", 32'(waits), 0);
            udf_m = 1;
        end else begin
            chk("pop_rdb", 32'(s_rdb), 0);
            chk("pop_wrb", 32'(s_wrb), 1);
            chk("pop_raddr", 32'(s_raddr), 32'(rp));
            chk("pop_ready0", 32'(s_ready), 0);
            chk("pop_waits", 32'(waits), 1);
            chk("pop_rdb_done", 32'(c_rdb), 1);
            chk("pop_data", rdata, 32'(q.pop_front()));
            chk("pop_err", 32'(err), 0);
            rp = (rp + 1) % DEPTH;
        end
    endtask

    task automatic chk_reset_outputs();
        chk("rst_wrb", 32'(WRB), 1);
        chk("rst_rdb", 32'(RDB), 1);
        chk("rst_waddr", 32'(WADDR), 0);
        chk("rst_raddr", 32'(RADDR), 0);
        chk("rst_din", 32'(FIFO_DIN), 0);
        chk("rst_prdata", PRDATA, 0);
        chk("rst_pready", 32'(PREADY), 1);
        chk("rst_pslverr", 32'(PSLVERR), 0);
        chk("rst_dc", 32'(DC_OUT), 0);
        chk("rst_irq", 32'(IRQ), 0);
    endtask

    initial begin
        PRESET = 1; PSEL = 0; PENABLE = 0; PWRITE = 0; PADDR = 0; PWDATA = 0;
        repeat (2) @(negedge PCLK);
        #1 chk_reset_outputs();
        PRESET = 0;
        rd(4'h4, 32'h1, "status_reset");
        rd(4'h8, 32'(DEPTH / 2), "thresh_reset");
        rd(4'hC, 0, "ctrl_reset");
        for (int i = 0; i < DEPTH; i++) push(9'($urandom_range(0, 511)));
        rd(4'h4, exp_status(), "status_full");
        push(9'h1AA);
        rd(4'h4, exp_status(), "status_ovf");
        for (int i = 0; i <= DEPTH; i++) pop();
        rd(4'h4, exp_status(), "status_udf");
        wr(4'h4, 32'h30);
        ovf_m = 0; udf_m = 0;
        rd(4'h4, exp_status(), "status_clear");
        for (int i = 0; i < 200; i++) push(9'($urandom_range(0, 511)));
        for (int i = 0; i < 200; i++) pop();
        for (int i = 0; i < 100; i++) push(9'($urandom_range(0, 511)));
        rd(4'h4, exp_status(), "status_wrap");
        for (int i = 0; i < 100; i++) pop();
        wr(4'h8, 3); thr_m = 3;
        ctrl_m = {1'b1, 3'($urandom_range(0, 7))};
        wr(4'hC, 32'(ctrl_m));
        chk("dc_out", 32'(DC_OUT), 32'(ctrl_m[2:0]));
        rd(4'hC, 32'(ctrl_m), "ctrl_read");
        push(9'($urandom_range(0, 511)));
        push(9'($urandom_range(0, 511)));
        rd(4'h4, exp_status(), "status_below_thr");
        chk("irq_below", 32'(IRQ), 0);
        push(9'($urandom_range(0, 511)));
        chk("irq_lag", 32'(IRQ), 0);
        @(negedge PCLK);
        chk("irq_rise", 32'(IRQ), 1);
        rd(4'h4, exp_status(), "status_eq_thr");
        pop();
        chk("irq_hold", 32'(IRQ), 1);
        @(negedge PCLK);
        chk("irq_fall", 32'(IRQ), 0);
        for (int i = 0; i < 6; i++) begin
            int t;
            t = (i == 0) ? 256 : (i == 1) ? 257 : $urandom_range(0, 511);
            wr(4'h8, 32'(t));
            thr_m = (t > DEPTH) ? DEPTH : t;
            rd(4'h8, 32'(thr_m), "thresh_sat");
            rd(4'h4, exp_status(), "status_thr");
        end
        while (q.size() < 5) push(9'($urandom_range(0, 511)));
        wr(4'hC, 32'h10);
        q.delete(); wp = 0; rp = 0; ctrl_m = 0;
        rd(4'hC, 0, "ctrl_flush_read");
        rd(4'h4, exp_status(), "status_flush");
        push(9'h055);
        pop();
        rd(4'h2, 0, "undecoded_rd2");
        rd(4'hF, 0, "undecoded_rdF");
        wr(4'h6, 32'hFFFF_FFFF);
        rd(4'h4, exp_status(), "status_undecoded_wr");
        push(9'h123);
        @(negedge PCLK);
        PSEL = 1; PENABLE = 0; PWRITE = 0; PADDR = 4'h0;
        @(negedge PCLK);
        PENABLE = 1;
        #1 chk("abort_rdb", 32'(RDB), 0);
        @(negedge PCLK);
        PRESET = 1; PSEL = 0; PENABLE = 0;
        #1 chk_reset_outputs();
        @(negedge PCLK);
        PRESET = 0;
        q.delete(); wp = 0; rp = 0; thr_m = DEPTH / 2; ovf_m = 0; udf_m = 0; ctrl_m = 0;
        rd(4'h4, exp_status(), "status_after_abort");
        rd(4'h8, 32'(DEPTH / 2), "thresh_after_abort");
        push(9'h0F0);
        pop();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/fifo_apb_port.md
# fifo_apb_port

APB slave that acts as the initiator side of the 4x single-write/single-read FIFO macro. It turns register accesses into the macro's address and strobe protocol: a write to the DATA register pushes a word, and a read from it pops one. The block owns the read/write pointers, the occupancy count, the threshold flags and the sticky error flags, and raises an interrupt on threshold. It sits between the peripheral APB bus and one FIFO macro instance, whose WCLKS and RCLKS are both tied to PCLK.

## Interface
- DEPTH, 256: FIFO words. Power of two, 4..256.
- AW, 8: macro address width.
- DW, 9: macro data width.
- PCLK  in  1  single clock for the block and the macro.
- PRESET  in  1  asynchronous, active-high reset.
- PSEL, PENABLE, PWRITE  in  1 each  APB control.
- PADDR  in  4  byte address: 0x0 DATA, 0x4 STATUS, 0x8 THRESH, 0xC CTRL.
- PWDATA  in  32  write data.
- PRDATA  out  32  read data.
- PREADY  out  1  transfer complete.
- PSLVERR  out  1  error response.
- WADDR, RADDR  out  AW  macro write/read address.
- FIFO_DIN  out  DW  macro write data.
- WRB, RDB  out  1  macro write/read strobes, active low.
- FIFO_DO  in  DW  macro read data, valid the cycle after the RDB-low edge.
- DC_OUT  out  3  macro DC_in[2:0] configuration.
- IRQ  out  1  threshold interrupt.

## Operation
- State: wptr, rptr (AW bits, wrap mod DEPTH), count (AW+1 bits, 0..DEPTH), thr (AW+1 bits), ovf, udf, ctrl[3:0], FSM {IDLE, RD_WAIT}.
- Derived flags: EMPTY = (count==0); FULL = (count==DEPTH); EQTH = (count==thr); GEQTH = (count>=thr). All unsigned.
- Write DATA, not FULL:
  - WRB=0 for the access cycle, with WADDR=wptr and FIFO_DIN=PWDATA[8:0].
  - wptr+1 and count+1 at the end of that cycle.
  - PREADY=1 and PSLVERR=0 in the same cycle.
- Write DATA, FULL: no strobe, pointers unchanged, ovf set to 1, PSLVERR=1.
- Read DATA, not EMPTY:
  - IDLE: RDB=0 with RADDR=rptr, PREADY=0, FSM moves to RD_WAIT.
  - RD_WAIT: PRDATA={23'b0, FIFO_DO}, PREADY=1; rptr+1 and count-1 at the end of the cycle; FSM returns to IDLE.
- Read DATA, EMPTY: PRDATA=0, PSLVERR=1, udf set to 1, zero wait states.
- STATUS read: bit0 EMPTY, bit1 FULL, bit2 EQTH, bit3 GEQTH, bit4 ovf, bit5 udf, bits[16:8] count; other bits 0.
- STATUS write: a 1 in bit4 or bit5 clears ovf or udf respectively.
- THRESH: read/write, bits[8:0]. Writes above DEPTH saturate to DEPTH.
- CTRL:
  - bits[2:0] DC_OUT; bit3 IRQ_EN.
  - bit4 FLUSH: self-clearing. Zeroes wptr, rptr and count in the write cycle. Reads back 0.
- IRQ = IRQ_EN & GEQTH, registered.
- Undecoded PADDR: read 0, write ignored, PSLVERR=0.
- Wrap-around: pointers roll from DEPTH-1 to 0. count is the only full/empty source.
- A FLUSH write is mutually exclusive with a pop because APB is single-transaction. A PRESET assertion during RD_WAIT aborts the read: FSM goes to IDLE and rptr is not advanced.

## Timing
- Reset values:
  - WRB=1, RDB=1; WADDR=RADDR=0; FIFO_DIN=0.
  - PRDATA=0, PREADY=1, PSLVERR=0.
  - count=0 (EMPTY=1); thr=DEPTH/2; ovf=udf=0; DC_OUT=0; IRQ=0; FSM=IDLE.
- Strobes are asserted only when PSEL&PENABLE is high; never in the setup phase.
- Latency:
  - Push, register access and error responses: 0 wait states.
  - Pop: exactly 1 wait state.
- PREADY is 1 outside access phases.
- Flags reflect count the cycle after the update. IRQ lags GEQTH by one cycle.
- WRB and RDB are never low in the same cycle. Each strobe is low for exactly one PCLK per accepted transfer.

## Test plan
- Reset, then read STATUS -> 0x00000001 (EMPTY only); WRB=RDB=1; PREADY=1.
- With DEPTH=256, push 0x000..0x0FF, then one more push -> 256 WRB pulses with WADDR 0..255; STATUS FULL=1, count=256; extra push gives PSLVERR=1 and ovf=1.
- Pop all 256 -> each pop has RDB low with RADDR=n, then PREADY=1 one cycle later with PRDATA=n; a 257th pop gives PRDATA=0, PSLVERR=1, udf=1. Write STATUS 0x30 -> ovf and udf clear.
- Wrap: push 200, pop 200, push 100 -> WADDR sequence 200..255 then 0..43; pop data matches in order.
- THRESH=3 with IRQ_EN=1: push 3 -> EQTH=GEQTH=1, and IRQ rises one cycle after the third push; pop 1 -> IRQ falls.
- Push 5, write CTRL FLUSH -> count=0, EMPTY=1, next push uses WADDR=0. Assert PRESET during a pop's wait cycle -> FSM IDLE, outputs at reset values.
